// File: rtl/bakraid_snd_out.sv
// Batrider/Bakraid audio output stage: sample FIFO, output-rate re-timing, DC blocker, 4.4 gain, pause fade.
// Define BAKRAID_SND_DCBLOCK_EN to build the DC blocker; otherwise stage 2 is a plain register.
module bakraid_snd_out #(
  parameter int FIFO_AW   = 3,
  parameter int DC_SHIFT  = 8,
  parameter int FADE_STEP = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IN_VALID,
  input  logic signed [15:0] IN_SAMPLE,
  input  logic               OUT_CEN,
  input  logic [7:0]         GAIN,
  input  logic               PAUSE,
  input  logic               CLR_FLAGS,
  output logic signed [15:0] OUT_L,
  output logic signed [15:0] OUT_R,
  output logic               OUT_STROBE,
  output logic               PEAK,
  output logic               OVF,
  output logic               UNF,
  output logic [FIFO_AW:0]   FILL
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [FIFO_AW:0]   FILL_ONE = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0]      CNT_ONE  = 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(FADE_STEP - 1);

  if (DC_SHIFT < 1 || DC_SHIFT > 19 || FADE_STEP < 1) begin : g_bad_params
    $error("bakraid_snd_out: DC_SHIFT must be 1..19 and FADE_STEP >= 1");
  end

  typedef enum logic [1:0] {PLAY, FADE_OUT, MUTED, FADE_IN} fade_state_e;

  function automatic logic ovr16(input logic signed [29:0] v);
    return (v > 30'sd32767) || (v < -30'sd32768);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [29:0] v);
    if (v > 30'sd32767)       return 16'sh7fff;
    else if (v < -30'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // ---------------- FIFO ----------------
  logic signed [15:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    fill_q, fill_d;
  logic                full, empty, push, pop;
  logic                ovf_q, unf_q;

  assign full  = fill_q[FIFO_AW];
  assign empty = (fill_q == '0);
  assign pop   = OUT_CEN && !empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign push  = IN_VALID && (!full || pop);

  // NOTE: every variable assigned in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    fill_d = fill_q;
    if (push && !pop)      fill_d = fill_q + FILL_ONE;
    else if (pop && !push) fill_d = fill_q - FILL_ONE;
  end

  // NOTE: the sample storage has no reset; pointers and fill count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= IN_SAMPLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      fill_q <= fill_d;
      if (IN_VALID && full && !pop) ovf_q <= 1'b1;
      else if (CLR_FLAGS)           ovf_q <= 1'b0;
      if (OUT_CEN && empty)         unf_q <= 1'b1;
      else if (CLR_FLAGS)           unf_q <= 1'b0;
    end
  end

  // ---------------- fade FSM ----------------
  fade_state_e    state_q;
  logic [4:0]     f_q;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= PLAY;
      f_q     <= 5'd16;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        PLAY: if (PAUSE) begin
          state_q <= FADE_OUT;
          cnt_q   <= '0;
        end
        MUTED: if (!PAUSE) begin
          state_q <= FADE_IN;
          cnt_q   <= '0;
        end
        FADE_OUT:
          if (!PAUSE) begin
            state_q <= (f_q == 5'd16) ? PLAY : FADE_IN;
            cnt_q   <= '0;
          end else if (OUT_CEN) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              f_q   <= f_q - 5'd1;
              if (f_q == 5'd1) state_q <= MUTED;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        FADE_IN:
          if (PAUSE) begin
            state_q <= (f_q == 5'd0) ? MUTED : FADE_OUT;
            cnt_q   <= '0;
          end else if (OUT_CEN) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              f_q   <= f_q + 5'd1;
              if (f_q == 5'd15) state_q <= PLAY;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        default: state_q <= PLAY;
      endcase
    end
  end

  // ---------------- pipeline ----------------
  logic               v1_q, v2_q, strobe_q, peak_q;
  logic signed [15:0] x_q, d_q, out_q, d_next;

`ifdef BAKRAID_SND_DCBLOCK_EN
  logic signed [19:0] x_prev_q, y_q, y_d;

  always_comb y_d = 20'(x_q) - x_prev_q + y_q - (y_q >>> DC_SHIFT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_prev_q <= '0;
      y_q      <= '0;
    end else if (v1_q) begin
      x_prev_q <= 20'(x_q);
      y_q      <= y_d;
    end
  end

  assign d_next = sat16(30'(y_d));
`else
  assign d_next = x_q;
`endif

  logic signed [24:0] gp;
  logic signed [23:0] p;
  logic signed [29:0] pf, q;

  always_comb begin
    gp = 25'(d_q) * 25'($signed({1'b0, GAIN}));
    p  = 24'(gp >>> 4);
    pf = 30'(p) * 30'($signed({1'b0, f_q}));
    q  = pf >>> 4;
  end

  // x_q doubles as the held sample: it only changes when a pop succeeds.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      x_q      <= '0;
      d_q      <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
      peak_q   <= 1'b0;
    end else begin
      v1_q     <= OUT_CEN;
      v2_q     <= v1_q;
      strobe_q <= v2_q;
      peak_q   <= v2_q && ovr16(q);
      if (pop)  x_q   <= mem_q[rd_ptr_q];
      if (v1_q) d_q   <= d_next;
      if (v2_q) out_q <= sat16(q);
    end
  end

  assign OUT_L      = out_q;
  assign OUT_R      = out_q;
  assign OUT_STROBE = strobe_q;
  assign PEAK       = peak_q;
  assign OVF        = ovf_q;
  assign UNF        = unf_q;
  assign FILL       = fill_q;
endmodule
